// File: rtl/game_timer_ctrl.sv
// Countdown game timer: 1 s prescaler, start/pause/expire FSM, and a serial double-dabble
// converter that updates all four BCD display digits together, 14 cycles after gameTime changes.
module game_timer_ctrl #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter logic [11:0] START_TIME  = 12'd120,
  parameter logic [11:0] BONUS       = 12'd10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        pause,
  input  logic        bonus,
  output logic [11:0] gameTime,
  output logic        running,
  output logic        timeUp,
  output logic [3:0]  HexIn1,
  output logic [3:0]  HexIn2,
  output logic [3:0]  HexIn3,
  output logic [3:0]  HexIn4,
  output logic        darkN,
  output logic        LampTest
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_RUN     = 2'd1;
  localparam logic [1:0] T_PAUSED  = 2'd2;
  localparam logic [1:0] T_EXPIRED = 2'd3;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_SHIFT = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  logic [1:0]    t_state_q, t_state_d;
  logic [11:0]   gt_q, gt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          time_up_q, time_up_d;

  logic [1:0]    c_state_q, c_state_d;
  logic          pend_q, pend_d;
  logic [11:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    it_q, it_d;
  logic [15:0]   dig_q, dig_d;
  logic          dark_q, dark_d;

  logic          cnt_en, tick, bonus_ok, gt_chg;
  logic [12:0]   sum;
  logic [11:0]   sat_sum;
  logic [27:0]   sh;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Pause freezes the prescaler even in the cycle RUN is still being left.
  assign cnt_en   = (t_state_q == T_RUN) && !pause;
  assign tick     = cnt_en && (presc_q == PRESC_MAX);
  assign bonus_ok = bonus && ((t_state_q == T_RUN) || (t_state_q == T_PAUSED));
  assign sum      = {1'b0, gt_q} + {1'b0, BONUS} - {12'd0, tick};
  assign sat_sum  = sum[12] ? 12'hFFF : sum[11:0];

  always_comb begin
    t_state_d = t_state_q;
    gt_d      = gt_q;
    presc_d   = presc_q;
    time_up_d = 1'b0;
    if (start) begin
      t_state_d = T_RUN;
      gt_d      = START_TIME;
      presc_d   = '0;
    end else begin
      if (cnt_en) presc_d = tick ? '0 : presc_q + PW'(1);
      if ((t_state_q == T_RUN) && pause) t_state_d = T_PAUSED;
      if ((t_state_q == T_PAUSED) && !pause) t_state_d = T_RUN;
      if (bonus_ok) begin
        gt_d = sat_sum;
      end else if (tick) begin
        if (gt_q <= 12'd1) begin
          gt_d      = '0;
          t_state_d = T_EXPIRED;
          time_up_d = 1'b1;
          presc_d   = '0;
        end else begin
          gt_d = gt_q - 12'd1;
        end
      end
    end
  end

  assign gt_chg = (gt_d != gt_q);
  assign sh     = {add3(bcd_q), bin_q};

  always_comb begin
    c_state_d = c_state_q;
    pend_d    = pend_q | gt_chg;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    it_d      = it_q;
    dig_d     = dig_q;
    dark_d    = dark_q;
    case (c_state_q)
      C_IDLE: if (pend_q || gt_chg) c_state_d = C_LOAD;
      C_LOAD: begin
        bin_d     = gt_q;
        bcd_d     = '0;
        it_d      = '0;
        pend_d    = gt_chg;
        c_state_d = C_SHIFT;
      end
      C_SHIFT: begin
        bcd_d = sh[26:11];
        bin_d = {sh[10:0], 1'b0};
        it_d  = it_q + 4'd1;
        if (it_q == 4'd11) c_state_d = C_DONE;
      end
      default: begin
        // BCD is zero exactly when the snapshot was zero.
        dig_d     = bcd_q;
        dark_d    = (bcd_q != 16'd0);
        c_state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      t_state_q <= T_IDLE;
      gt_q      <= '0;
      presc_q   <= '0;
      time_up_q <= 1'b0;
      c_state_q <= C_IDLE;
      pend_q    <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      it_q      <= '0;
      dig_q     <= '0;
      dark_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      gt_q      <= gt_d;
      presc_q   <= presc_d;
      time_up_q <= time_up_d;
      c_state_q <= c_state_d;
      pend_q    <= pend_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      it_q      <= it_d;
      dig_q     <= dig_d;
      dark_q    <= dark_d;
    end
  end

  assign gameTime = gt_q;
  assign running  = (t_state_q == T_RUN);
  assign timeUp   = time_up_q;
  assign HexIn1   = dig_q[3:0];
  assign HexIn2   = dig_q[7:4];
  assign HexIn3   = dig_q[11:8];
  assign HexIn4   = dig_q[15:12];
  assign darkN    = dark_q;
  assign LampTest = 1'b0;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with TICK_CYCLES=16, START_TIME=12, BONUS=10.
module tb_game_timer_ctrl;

  logic        clk = 1'b0;
  logic        resetN, start, pause, bonus;
  logic [11:0] gameTime;
  logic        running, timeUp, darkN, LampTest;
  logic [3:0]  HexIn1, HexIn2, HexIn3, HexIn4;

  int n_chk  = 0;
  int n_fail = 0;

  game_timer_ctrl #(.TICK_CYCLES(16), .START_TIME(12'd12), .BONUS(12'd10)) dut (
    .clk(clk), .resetN(resetN), .start(start), .pause(pause), .bonus(bonus),
    .gameTime(gameTime), .running(running), .timeUp(timeUp),
    .HexIn1(HexIn1), .HexIn2(HexIn2), .HexIn3(HexIn3), .HexIn4(HexIn4),
    .darkN(darkN), .LampTest(LampTest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        st, pa, bo;
    logic [11:0] gt;
    logic        run, tu;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input int n, input logic st, input logic pa, input logic bo,
                      input logic [11:0] gt, input logic run, input logic tu);
    vec_t v;
    v.n = n; v.st = st; v.pa = pa; v.bo = bo; v.gt = gt; v.run = run; v.tu = tu;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int dig_val();
    return int'(HexIn4) * 1000 + int'(HexIn3) * 100 + int'(HexIn2) * 10 + int'(HexIn1);
  endfunction

  function automatic bit dig_ok();
    return (HexIn1 <= 4'd9) && (HexIn2 <= 4'd9) && (HexIn3 <= 4'd9) && (HexIn4 <= 4'd9);
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    bit ok;
    // {cycles, start, pause, bonus, gameTime, running, timeUp}, from reset
    addv(1,   1, 0, 0, 12, 1, 0);
    addv(15,  0, 0, 0, 12, 1, 0);
    addv(1,   0, 0, 0, 11, 1, 0);
    addv(5,   0, 0, 0, 11, 1, 0);
    addv(1,   0, 1, 0, 11, 0, 0);
    addv(39,  0, 1, 0, 11, 0, 0);
    addv(1,   0, 0, 0, 11, 1, 0);
    addv(10,  0, 0, 0, 11, 1, 0);
    addv(1,   0, 0, 0, 10, 1, 0);
    addv(1,   0, 1, 1, 20, 0, 0);
    addv(3,   0, 1, 0, 20, 0, 0);
    addv(1,   0, 0, 0, 20, 1, 0);
    addv(15,  0, 0, 0, 20, 1, 0);
    addv(1,   0, 0, 0, 19, 1, 0);
    addv(208, 0, 0, 0, 6,  1, 0);
    addv(15,  0, 0, 0, 6,  1, 0);
    addv(1,   0, 0, 0, 5,  1, 0);
    addv(15,  0, 0, 0, 5,  1, 0);
    addv(1,   0, 0, 1, 14, 1, 0);
    addv(223, 0, 0, 0, 1,  1, 0);
    addv(1,   0, 0, 0, 0,  0, 1);

    resetN = 1'b0; start = 1'b0; pause = 1'b0; bonus = 1'b0;
    step(3);
    chk("rst.gameTime", gameTime, 0);
    chk("rst.running", running, 0);
    chk("rst.timeUp", timeUp, 0);
    chk("rst.digits", dig_val(), 0);
    chk("rst.darkN", darkN, 0);
    chk("rst.LampTest", LampTest, 0);

    // Conversion latency after start
    resetN = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("A.gameTime", gameTime, 12);
    step(13);
    chk("A.digits_t13", dig_val(), 0);
    chk("A.darkN_t13", darkN, 0);
    step(1);
    chk("A.HexIn1", HexIn1, 2);
    chk("A.HexIn2", HexIn2, 1);
    chk("A.darkN", darkN, 1);
    step(2);
    chk("A.gameTime_t16", gameTime, 11);

    resetN = 1'b0;
    step(2);
    chk("A.rst_running", running, 0);
    resetN = 1'b1;

    foreach (vt[i]) begin
      start = vt[i].st; pause = vt[i].pa; bonus = vt[i].bo;
      step(vt[i].n);
      chk($sformatf("vec%0d.gameTime", i), gameTime, vt[i].gt);
      chk($sformatf("vec%0d.running", i), running, vt[i].run);
      chk($sformatf("vec%0d.timeUp", i), timeUp, vt[i].tu);
    end
    start = 1'b0; pause = 1'b0; bonus = 1'b0;

    // Expiry: darkN falls 14 cycles after gameTime reaches 0
    step(1);
    chk("B.timeUp_one_cycle", timeUp, 0);
    step(12);
    chk("B.darkN_t13", darkN, 1);
    chk("B.HexIn1_t13", HexIn1, 1);
    step(1);
    chk("B.darkN_t14", darkN, 0);
    chk("B.digits_t14", dig_val(), 0);
    for (int k = 0; k < 20; k++) begin
      bonus = 1'b1; step(1);
      bonus = 1'b0; step(1);
    end
    chk("B.expired_gameTime", gameTime, 0);
    chk("B.expired_running", running, 0);

    // Saturation near 4095
    start = 1'b1; pause = 1'b1;
    step(1);
    start = 1'b0;
    chk("C.start_running", running, 1);
    step(1);
    chk("C.paused_running", running, 0);
    for (int k = 0; k < 408; k++) begin
      bonus = 1'b1; step(1);
      bonus = 1'b0; step(1);
    end
    chk("C.gameTime_4092", gameTime, 4092);
    pause = 1'b0;
    step(1);
    chk("C.resume_running", running, 1);
    step(32);
    chk("C.gameTime_4090", gameTime, 4090);
    pause = 1'b1; bonus = 1'b1;
    step(1);
    bonus = 1'b0;
    chk("C.gameTime_sat", gameTime, 4095);
    step(40);
    chk("C.HexIn4", HexIn4, 4);
    chk("C.HexIn3", HexIn3, 0);
    chk("C.HexIn2", HexIn2, 9);
    chk("C.HexIn1", HexIn1, 5);
    chk("C.darkN", darkN, 1);
    bonus = 1'b1; step(1); bonus = 1'b0;
    chk("C.sat_hold", gameTime, 4095);

    // Coalesced bonus pulses never show a mixed value
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("D.reload", gameTime, 12);
    step(30);
    chk("D.digits_12", dig_val(), 12);
    for (int k = 0; k < 40; k++) begin
      bonus = (k == 0 || k == 2 || k == 4);
      step(1);
      bonus = 1'b0;
      v  = dig_val();
      ok = dig_ok() && (v == 12 || v == 22 || v == 32 || v == 42);
      chk($sformatf("D.digits_consistent%0d", k), int'(ok) * v, v == 0 ? 1 : v);
    end
    chk("D.gameTime_final", gameTime, 42);
    chk("D.digits_final", dig_val(), 42);

    // Start with pause held mid-countdown, then reset during SHIFT
    pause = 1'b0;
    step(4);
    chk("E.running", running, 1);
    start = 1'b1; pause = 1'b1;
    step(1);
    start = 1'b0;
    chk("E.reload", gameTime, 12);
    chk("E.reload_running", running, 1);
    step(1);
    chk("E.paused_running", running, 0);
    step(2);
    resetN = 1'b0;
    step(1);
    chk("E.rst_gameTime", gameTime, 0);
    chk("E.rst_running", running, 0);
    chk("E.rst_timeUp", timeUp, 0);
    chk("E.rst_digits", dig_val(), 0);
    chk("E.rst_darkN", darkN, 0);
    resetN = 1'b1; pause = 1'b0; bonus = 1'b1;
    step(1);
    bonus = 1'b0;
    chk("E.idle_bonus_ignored", gameTime, 0);
    step(20);
    chk("E.idle_digits", dig_val(), 0);
    chk("E.idle_darkN", darkN, 0);
    chk("E.idle_running", running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
